// File: rtl/nibble_serial_addsub_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nibble_serial_addsub_ctrl                                                  |
// | Runs a 4*NIBBLES-bit add/subtract through one 4-bit ripple adder, one      |
// | nibble per clock, LSB nibble first, with a start/busy/done handshake.      |
// | Optional: ADDSUB_OVF_DETECT_EN enables the signed overflow flag o_ovf.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module adder4bitV1 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [4:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fa
    assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
  end

  assign o_cout = w_c[4];
endmodule

module nibble_serial_addsub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_sub,
  input  logic [4*NIBBLES-1:0]   i_a,
  input  logic [4*NIBBLES-1:0]   i_b,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [4*NIBBLES-1:0]   o_result,
  output logic                   o_cout,
  output logic                   o_ovf
);
  localparam int WIDTH = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_busy;
  logic               w_done;
  logic               w_accept;
  logic               w_last;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_result;
  logic               r_cout;

  logic [IDX_W+1:0]   w_lsb;
  logic [3:0]         w_a_nib;
  logic [3:0]         w_b_nib;
  logic [3:0]         w_sum;
  logic               w_cout;

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_last   = (r_state == S_RUN) && (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (r_idx == LAST_IDX) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_lsb   = {r_idx, 2'b00};
  assign w_a_nib = r_a[w_lsb +: 4];
  assign w_b_nib = r_b[w_lsb +: 4];

  adder4bitV1 u_adder (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Subtraction is A + ~B + 1: B is inverted at capture and the +1 rides in as the first carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_sub ? ~i_b : i_b;
      r_carry <= i_sub;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_result[w_lsb +: 4] <= w_sum;
      r_carry              <= w_cout;
      r_idx                <= r_idx + 1'b1;
      if (w_last) r_cout <= w_cout;
    end
  end

`ifdef ADDSUB_OVF_DETECT_EN
  logic r_ovf;
  logic w_ovf_final;

  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  assign w_ovf_final = (w_a_nib[3] ^ w_b_nib[3] ^ w_sum[3]) ^ w_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= w_ovf_final;
    end
  end

  assign o_ovf = r_ovf;
`else
  assign o_ovf = 1'b0;
`endif

  assign o_busy   = w_busy;
  assign o_done   = w_done;
  assign o_result = r_result;
  assign o_cout   = r_cout;
endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_addsub_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_nibble_serial_addsub_ctrl                                               |
// | Directed and random add/sub operations against an arithmetic model.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_nibble_serial_addsub_ctrl;
  localparam int NIBBLES = 4;
  localparam int WIDTH   = 4 * NIBBLES;
  localparam int BUDGET  = 30;

  logic             clk;
  logic             rst_n;
  logic             i_start;
  logic             i_sub;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic             o_cout;
  logic             o_ovf;

  int checks = 0;
  int errors = 0;

  nibble_serial_addsub_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (i_start),
    .i_sub    (i_sub),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result),
    .o_cout   (o_cout),
    .o_ovf    (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                       output logic [WIDTH-1:0] res, output logic cout, output logic ovf);
    int ua, ub, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    if (sub) begin
      res  = WIDTH'(ua - ub);
      cout = (ua >= ub);
      sr   = sa - sb;
    end else begin
      res  = WIDTH'(ua + ub);
      cout = (ua + ub) > 65535;
      sr   = sa + sb;
    end
`ifdef ADDSUB_OVF_DETECT_EN
    ovf = (sr > 32767) || (sr < -32768);
`else
    ovf = 1'b0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
    i_a     = a;
    i_b     = b;
    i_sub   = sub;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!o_done && cyc < BUDGET) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
    logic [WIDTH-1:0] e_res;
    logic             e_cout;
    logic             e_ovf;
    int               cyc;
    model(a, b, sub, e_res, e_cout, e_ovf);
    issue(a, b, sub);
    wait_done(cyc);
    check("latency", cyc, NIBBLES);
    check("result", o_result, e_res);
    check("cout", o_cout, e_cout);
    check("ovf", o_ovf, e_ovf);
    check("busy_in_done", o_busy, 1);
    tick();
    check("done_one_cycle", o_done, 0);
    check("busy_after", o_busy, 0);
    check("result_hold", o_result, e_res);
  endtask

  initial begin
    int               cyc;
    bit               saw_done;
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH-1:0] specials [4];

    specials[0] = 16'h0000;
    specials[1] = 16'hFFFF;
    specials[2] = 16'h8000;
    specials[3] = 16'h7FFF;

    rst_n   = 1'b0;
    i_start = 1'b0;
    i_sub   = 1'b0;
    i_a     = '0;
    i_b     = '0;
    #3;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_result", o_result, 0);
    check("rst_cout", o_cout, 0);
    check("rst_ovf", o_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    do_op(16'h1234, 16'h0FFF, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0);
    do_op(16'h0005, 16'h0007, 1'b1);
    do_op(16'h0007, 16'h0005, 1'b1);
    do_op(16'h7FFF, 16'h0001, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b1);

    // Starts presented while busy (RUN and DONE) must be dropped.
    issue(16'h1111, 16'h2222, 1'b0);
    i_a = 16'hAAAA;
    i_b = 16'hAAAA;
    tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    check("ign_no_early_done", o_done, 0);
    tick();
    check("ign_done", o_done, 1);
    check("ign_result", o_result, 16'h3333);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("ign_done_cycle_busy", o_busy, 0);
    check("ign_done_cycle_done", o_done, 0);
    do_op(16'h4321, 16'h1234, 1'b1);

    // Asynchronous reset in the middle of a run.
    issue(16'hF0F0, 16'h0F0F, 1'b0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_done", o_done, 0);
    check("mid_rst_result", o_result, 0);
    check("mid_rst_cout", o_cout, 0);
    check("mid_rst_ovf", o_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_done || o_busy) saw_done = 1'b1;
    end
    check("post_rst_idle", saw_done, 0);
    do_op(16'h0001, 16'h0001, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : WIDTH'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : WIDTH'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      do_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
